// File: rtl/pz_scan_ctrl.sv
// Sequencer and configuration front-end for the pole/zero evaluator: shadow/active
// coefficient registers, raster scan of sample points, in-flight tracking and frame completion.
module pz_scan_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int POLE_COUNT      = 4,
  parameter int ZERO_COUNT      = 4,
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [3:0]                         cfg_addr,
  input  logic [2*DATA_WIDTH-1:0]            cfg_wdata,
  input  logic                               start,
  output logic                               pt_valid,
  input  logic                               pt_ready,
  output logic [DATA_WIDTH-1:0]              x_out,
  output logic [DATA_WIDTH-1:0]              y_out,
  output logic                               pt_last,
  output logic [POLE_COUNT*2*DATA_WIDTH-1:0] poles_flat,
  output logic [ZERO_COUNT*2*DATA_WIDTH-1:0] zeros_flat,
  input  logic                               res_valid,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err
);

  localparam int CW    = 2 * DATA_WIDTH;
  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_SCAN,
    S_DRAIN
  } state_e;

  state_e                       state_q, state_d;
  logic                         armed_q, armed_d;

  logic [POLE_COUNT*CW-1:0]     sh_poles_q, sh_poles_d;
  logic [ZERO_COUNT*CW-1:0]     sh_zeros_q, sh_zeros_d;
  logic [DATA_WIDTH-1:0]        sh_xs_q, sh_xs_d;
  logic [DATA_WIDTH-1:0]        sh_ys_q, sh_ys_d;
  logic [DATA_WIDTH-1:0]        sh_step_q, sh_step_d;

  logic [POLE_COUNT*CW-1:0]     poles_q, poles_d;
  logic [ZERO_COUNT*CW-1:0]     zeros_q, zeros_d;
  logic [DATA_WIDTH-1:0]        xs_q, xs_d;
  logic [DATA_WIDTH-1:0]        ys_q, ys_d;
  logic [DATA_WIDTH-1:0]        step_q, step_d;

  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [DATA_WIDTH-1:0]        x_q, x_d;
  logic [DATA_WIDTH-1:0]        y_q, y_d;
  logic [IF_W-1:0]              inflight_q, inflight_d;

  logic                         pt_valid_q, pt_valid_d;
  logic [DATA_WIDTH-1:0]        x_out_q, x_out_d;
  logic [DATA_WIDTH-1:0]        y_out_q, y_out_d;
  logic                         pt_last_q, pt_last_d;
  logic                         err_q, err_d;
  logic                         frame_done_c;

  logic                         accept;
  logic                         at_last_col;
  logic                         at_last_row;

  assign accept      = pt_valid_q && pt_ready;
  assign at_last_col = (col_q == COL_W'(H_RES - 1));
  assign at_last_row = (row_q == ROW_W'(V_RES - 1));

  // Config port only ever touches the shadow copies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sh_poles_d = sh_poles_q;
    sh_zeros_d = sh_zeros_q;
    sh_xs_d    = sh_xs_q;
    sh_ys_d    = sh_ys_q;
    sh_step_d  = sh_step_q;
    if (cfg_we) begin
      for (int k = 0; k < POLE_COUNT; k++) begin
        if (cfg_addr == 4'(k)) sh_poles_d[k*CW +: CW] = cfg_wdata;
      end
      for (int k = 0; k < ZERO_COUNT; k++) begin
        if (cfg_addr == 4'(POLE_COUNT + k)) sh_zeros_d[k*CW +: CW] = cfg_wdata;
      end
      if (cfg_addr == 4'd8)  sh_xs_d   = cfg_wdata[DATA_WIDTH-1:0];
      if (cfg_addr == 4'd9)  sh_ys_d   = cfg_wdata[DATA_WIDTH-1:0];
      if (cfg_addr == 4'd10) sh_step_d = cfg_wdata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    poles_d      = poles_q;
    zeros_d      = zeros_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    step_d       = step_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    inflight_d   = inflight_q;
    err_d        = err_q;
    pt_valid_d   = 1'b0;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    pt_last_d    = 1'b0;
    frame_done_c = 1'b0;

    // A result in the same cycle as an accept cancels out.
    if (accept && !res_valid) begin
      inflight_d = inflight_q + IF_W'(1);
    end else if (!accept && res_valid && inflight_q != '0) begin
      inflight_d = inflight_q - IF_W'(1);
    end
    if (res_valid && inflight_q == '0) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // armed_q masks a start coinciding with reset release.
        if (start && armed_q) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        poles_d    = sh_poles_q;
        zeros_d    = sh_zeros_q;
        xs_d       = sh_xs_q;
        ys_d       = sh_ys_q;
        step_d     = sh_step_q;
        col_d      = '0;
        row_d      = '0;
        x_d        = sh_xs_q;
        y_d        = sh_ys_q;
        inflight_d = '0;
        err_d      = 1'b0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        if (accept) begin
          if (!at_last_col) begin
            col_d = col_q + COL_W'(1);
            x_d   = x_q + step_q;
          end else begin
            col_d = '0;
            x_d   = xs_q;
            if (at_last_row) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
              y_d   = y_q - step_q;
            end
          end
        end
        // A held sample stays valid: without an accept in-flight can only fall.
        pt_valid_d = (state_d == S_SCAN) && (inflight_d < IF_W'(MAX_OUTSTANDING));
        x_out_d    = x_d;
        y_out_d    = y_d;
        pt_last_d  = pt_valid_d && (col_d == COL_W'(H_RES - 1)) && (row_d == ROW_W'(V_RES - 1));
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          frame_done_c = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: coefficient arrays are plain flops, so they take the async reset like everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      sh_poles_q <= '0;
      sh_zeros_q <= '0;
      sh_xs_q    <= '0;
      sh_ys_q    <= '0;
      sh_step_q  <= '0;
      poles_q    <= '0;
      zeros_q    <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      step_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      pt_valid_q <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      pt_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      armed_q    <= armed_d;
      sh_poles_q <= sh_poles_d;
      sh_zeros_q <= sh_zeros_d;
      sh_xs_q    <= sh_xs_d;
      sh_ys_q    <= sh_ys_d;
      sh_step_q  <= sh_step_d;
      poles_q    <= poles_d;
      zeros_q    <= zeros_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      step_q     <= step_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      pt_valid_q <= pt_valid_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      pt_last_q  <= pt_last_d;
      err_q      <= err_d;
    end
  end

  assign pt_valid   = pt_valid_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign pt_last    = pt_last_q;
  assign poles_flat = poles_q;
  assign zeros_flat = zeros_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_c;
  assign err        = err_q;

endmodule

// File: tb/tb_pz_scan_ctrl.sv
// Directed bench for pz_scan_ctrl on a 4x3 raster: scan order, config commit,
// backpressure, outstanding limit, spurious results and mid-frame reset.
module tb_pz_scan_ctrl;

  localparam int DW = 16;
  localparam int PC = 4;
  localparam int ZC = 4;
  localparam int HR = 4;
  localparam int VR = 3;
  localparam int MO = 8;
  localparam int NS = HR * VR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic [2*DW-1:0]   cfg_wdata = '0;
  logic              start = 1'b0;
  logic              pt_ready = 1'b0;
  logic              res_valid = 1'b0;
  logic              pt_valid;
  logic [DW-1:0]     x_out;
  logic [DW-1:0]     y_out;
  logic              pt_last;
  logic [PC*2*DW-1:0] poles_flat;
  logic [ZC*2*DW-1:0] zeros_flat;
  logic              busy;
  logic              frame_done;
  logic              err;

  pz_scan_ctrl #(
    .DATA_WIDTH(DW), .POLE_COUNT(PC), .ZERO_COUNT(ZC),
    .H_RES(HR), .V_RES(VR), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .pt_valid(pt_valid), .pt_ready(pt_ready), .x_out(x_out), .y_out(y_out),
    .pt_last(pt_last), .poles_flat(poles_flat), .zeros_flat(zeros_flat), .res_valid(res_valid),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_ret = 0;
  int n_done = 0;
  bit auto_res = 1'b0;
  logic [2:0] res_pipe = '0;

  // Expected raster for x_start=FFFE, y_start=0001, step=0001.
  logic [DW-1:0] exp_x [HR] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [DW-1:0] exp_y [VR] = '{16'h0001, 16'h0000, 16'hFFFF};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any accept on this edge, then return results 3 cycles later if enabled.
  task automatic step();
    bit acc;
    acc = pt_valid && pt_ready;
    if (acc) begin
      if (n_acc < NS) begin
        check("sample_x", x_out, exp_x[n_acc % HR]);
        check("sample_y", y_out, exp_y[n_acc / HR]);
        check("sample_last", pt_last, n_acc == NS - 1);
      end else begin
        check("accept_overrun", n_acc, NS - 1);
      end
      n_acc++;
    end
    if (res_valid) n_ret++;
    @(posedge clk);
    #1;
    if (frame_done) n_done++;
    res_pipe = {res_pipe[1:0], acc};
    if (auto_res) res_valid = res_pipe[2];
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic start_frame();
    n_acc  = 0;
    n_ret  = 0;
    n_done = 0;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic load_raster_cfg();
    cfg_write(4'd8,  32'h0000_FFFE);
    cfg_write(4'd9,  32'h0000_0001);
    cfg_write(4'd10, 32'h0000_0001);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pt_valid", pt_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_pt_last", pt_last, 0);
    check("rst_poles", poles_flat, 0);
    check("rst_zeros", zeros_flat, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);

    // start in the release cycle must be dropped
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_at_release_ignored", busy, 0);

    // ---- frame 1: full raster with 3-cycle result latency ----
    load_raster_cfg();
    cfg_write(4'd0,  32'h0001_0002);
    cfg_write(4'd6,  32'h0A0B_0C0D);
    cfg_write(4'd11, 32'hDEAD_BEEF);
    cfg_write(4'd15, 32'h1234_5678);
    check("shadow_not_active", poles_flat, 0);

    pt_ready = 1'b1;
    auto_res = 1'b1;
    start_frame();
    check("commit_busy", busy, 1);
    check("commit_no_valid", pt_valid, 0);
    step();
    check("commit_poles", poles_flat, {96'h0, 32'h0001_0002});
    check("commit_zeros", zeros_flat, {32'h0, 32'h0A0B_0C0D, 64'h0});
    check("scan_reg_stage_no_valid", pt_valid, 0);
    step();
    check("first_valid_latency", pt_valid, 1);

    for (int i = 0; i < 20 && n_acc < 2; i++) step();
    cfg_write(4'd0, 32'h0005_0003);
    check("pole_mid_frame_held", poles_flat, {96'h0, 32'h0001_0002});

    for (int i = 0; i < 20 && n_acc < 5; i++) step();
    pt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", pt_valid, 1);
      check("bp_x", x_out, exp_x[1]);
      check("bp_y", y_out, exp_y[1]);
    end
    check("bp_no_accept", n_acc, 5);
    pt_ready = 1'b1;

    for (int i = 0; i < 100 && n_done == 0; i++) step();
    repeat (3) step();
    check("f1_accepts", n_acc, NS);
    check("f1_returns", n_ret, NS);
    check("f1_done_once", n_done, 1);
    check("f1_err", err, 0);
    check("f1_idle", busy, 0);
    check("f1_poles_still_old", poles_flat, {96'h0, 32'h0001_0002});

    // ---- frame 2: outstanding limit, results returned by hand ----
    auto_res  = 1'b0;
    res_valid = 1'b0;
    res_pipe  = '0;
    start_frame();
    step();
    check("pole_commit_next_frame", poles_flat, {96'h0, 32'h0005_0003});
    for (int i = 0; i < 20; i++) step();
    check("limit_accepts", n_acc, MO);
    check("limit_valid_low", pt_valid, 0);

    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("limit_release_valid", pt_valid, 1);
    step();
    check("limit_one_more", n_acc, MO + 1);
    check("limit_low_again", pt_valid, 0);
    repeat (2) step();
    check("limit_no_extra", n_acc, MO + 1);

    res_valid = 1'b1;
    step();
    check("pre_same_cycle_valid", pt_valid, 1);
    step();
    res_valid = 1'b0;
    check("same_cycle_accept", n_acc, MO + 2);
    check("same_cycle_count_held", pt_valid, 1);
    step();
    check("after_same_cycle_accept", n_acc, MO + 3);
    check("after_same_cycle_full", pt_valid, 0);

    for (int i = 0; i < 40 && (n_acc < NS || n_acc > n_ret); i++) begin
      res_valid = (n_acc > n_ret);
      step();
    end
    res_valid = 1'b0;
    for (int i = 0; i < 10 && n_done == 0; i++) step();
    check("f2_accepts", n_acc, NS);
    check("f2_done", n_done, 1);
    check("f2_err", err, 0);

    // ---- spurious result while idle ----
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("spurious_err", err, 1);
    check("spurious_busy", busy, 0);
    step();
    check("err_sticky", err, 1);

    // ---- frame 3: reset after the 5th accept ----
    auto_res = 1'b1;
    res_pipe = '0;
    start_frame();
    step();
    check("err_cleared_by_start", err, 0);
    for (int i = 0; i < 30 && n_acc < 5; i++) step();
    check("abort_point", n_acc, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pt_valid", pt_valid, 0);
    check("async_rst_x_out", x_out, 0);
    check("async_rst_y_out", y_out, 0);
    check("async_rst_pt_last", pt_last, 0);
    check("async_rst_poles", poles_flat, 0);
    check("async_rst_zeros", zeros_flat, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_err", err, 0);
    check("abort_no_done", n_done, 0);
    auto_res  = 1'b0;
    res_valid = 1'b0;
    res_pipe  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    load_raster_cfg();
    auto_res = 1'b1;
    start_frame();
    for (int i = 0; i < 100 && n_done == 0; i++) step();
    check("f4_accepts", n_acc, NS);
    check("f4_done", n_done, 1);
    check("f4_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
